ray_param_regfile: RTL and testbench
====================================

Name: ray_param_regfile

Overview:
Parametrised successor to the ray marcher's AXI-Lite register file, for scene parameters such as light position, camera vectors and normal factor. Supports configurable depth, per-byte write strobes, correct SLVERR decoding, and a read-only status word. Adds frame-synchronous shadowing: software writes land in a working array, and the array seen by the ray unit is updated only at a frame boundary, so a frame never renders with half-updated parameters. The AXI-Lite slave and the stream datapath share one clock.

Parameters:
AXI_LITE_ADDR_WIDTH, 8, byte-address width; must satisfy AXI_LITE_ADDR_WIDTH-2 >= clog2(REG_FILE_SIZE+1)
REG_FILE_SIZE, 16, number of 32-bit R/W parameter registers
RESET_VALUES, {REG_FILE_SIZE{32'h0}}, flat vector of per-register reset values; register i is bits [32*i+:32]

Ports:
aclk  in  1  single clock for the AXI-Lite slave and the parameter outputs
aresetn  in  1  synchronous, active-low reset
s_axi_lite_awaddr  in  AXI_LITE_ADDR_WIDTH  write byte address
s_axi_lite_awvalid/awready  in/out  1  write-address handshake
s_axi_lite_wdata  in  32  write data
s_axi_lite_wstrb  in  4  byte enables
s_axi_lite_wvalid/wready  in/out  1  write-data handshake
s_axi_lite_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_lite_bvalid/bready  out/in  1  write-response handshake
s_axi_lite_araddr  in  AXI_LITE_ADDR_WIDTH  read byte address
s_axi_lite_arvalid/arready  in/out  1  read-address handshake
s_axi_lite_rdata  out  32  read data
s_axi_lite_rresp  out  2  00 OKAY, 10 SLVERR
s_axi_lite_rvalid/rready  out/in  1  read-data handshake
frame_sync  in  1  one-cycle pulse at start of frame (sof accepted by the packer)
params_out  out  32*REG_FILE_SIZE  shadow registers; register i at [32*i+:32]
params_updated  out  1  one-cycle pulse when params_out has just changed

Behaviour:
- Reset, synchronous on aresetn=0:
  - working and shadow arrays take RESET_VALUES.
  - pending=0, frame_count=0.
  - Both FSMs go to IDLE.
  - bvalid=rvalid=0, bresp=rresp=00, rdata=0, params_updated=0.
  - arready=awready=wready=1 in the first cycle after reset.
  - A transaction in flight when reset asserts is dropped; no response is issued for it.
- Decode: idx = addr[AXI_LITE_ADDR_WIDTH-1:2]. The address is decoded at full width and never truncated.
  - idx<REG_FILE_SIZE: parameter register.
  - idx==REG_FILE_SIZE: STATUS, read-only.
  - any other idx: invalid.
- STATUS word: [31:16]=frame_count, [0]=pending, all other bits 0.
- Write FSM states: IDLE, WAIT_DATA, WAIT_ADDR, WRITE, RESP.
  - awready=1 in IDLE and WAIT_ADDR. wready=1 in IDLE and WAIT_DATA.
  - IDLE: AW only goes to WAIT_DATA; W only goes to WAIT_ADDR; AW and W together go to WRITE. Address, data and strobe are captured on their handshakes.
  - WAIT_DATA or WAIT_ADDR go to WRITE when the missing half arrives.
  - WRITE (one cycle): for a valid register, update each byte b where wstrb[b]=1, set pending=1 and set bresp=00. For STATUS or an invalid index, write nothing and set bresp=10.
  - WRITE then RESP. In RESP, bvalid=1 and bresp is held stable until bready; then IDLE.
  - Earliest bvalid is 2 cycles after the AW/W acceptance edge.
- Read FSM states: IDLE, FETCH, READ.
  - arready=1 only in IDLE. An accepted AR goes to FETCH, FETCH goes to READ.
  - READ: rvalid=1; rdata/rresp are stable until rready; then IDLE.
  - Register reads return the working value, not the shadow.
  - An invalid index returns rdata=0 with rresp=10.
  - Read and write FSMs run independently and concurrently.
- Commit:
  - On a cycle with frame_sync=1 and pending=1, the shadow array takes the working array as it stands at the start of that cycle, i.e. before any same-cycle WRITE.
  - params_out changes on the following edge, and params_updated=1 in that same next cycle.
  - pending clears on commit, unless a WRITE to a valid register occurs in the commit cycle; then pending stays 1 and that write is committed at the next frame_sync.
  - frame_sync with pending=0 leaves the shadow unchanged and does not assert params_updated.
- frame_count increments on every frame_sync and wraps from 0xFFFF to 0x0000.
- params_out is driven directly from the shadow flops (registered, glitch-free).

Test Plan:
- Write reg3=32'h0100_0000 with wstrb=4'hF, no frame_sync. Required: bresp=00, STATUS reads 0x0000_0001, readback of reg3 returns 0x0100_0000, and params_out[3] still holds its reset value. Pulse frame_sync. Required: params_out[3]=0x0100_0000 and params_updated=1 one cycle later, then STATUS reads 0x0001_0000.
- reg5=0xAABBCCDD, then write 0x11223344 with wstrb=4'b0010. Required: readback 0xAABB33DD.
- Present W two cycles before AW for reg1. Required: write completes with bvalid exactly 2 cycles after the AW acceptance edge. Hold bready=0 for 5 cycles. Required: bvalid and bresp stay stable throughout.
- Read idx=REG_FILE_SIZE+1 with rready held low for 3 cycles. Required: rdata=0, rresp=10, rvalid held. Write to the STATUS address. Required: bresp=10, STATUS unchanged.
- WRITE to reg0 in the same cycle as frame_sync, with pending already set by an earlier reg2 write. Required: shadow gets the new reg2 and the old reg0, pending remains 1. The next frame_sync commits reg0.
- Drive 65536 frame_sync pulses. Required: frame_count wraps to 0. Assert aresetn=0 while in WAIT_DATA. Required: no bvalid, all registers back to RESET_VALUES, awready=1 the cycle after release.

Source files
------------

// File: rtl/ray_param_regfile.sv
// AXI-Lite scene-parameter register file with frame-synchronous shadow copy for the ray unit.
// Write response 2 cycles after AW/W acceptance, read data 2 cycles after AR; each channel stalls on its ready.
module ray_param_regfile #(
  parameter int AXI_LITE_ADDR_WIDTH = 8,
  parameter int REG_FILE_SIZE = 16,
  parameter logic [32*REG_FILE_SIZE-1:0] RESET_VALUES = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_awaddr,
  input  logic                           s_axi_lite_awvalid,
  output logic                           s_axi_lite_awready,
  input  logic [31:0]                    s_axi_lite_wdata,
  input  logic [3:0]                     s_axi_lite_wstrb,
  input  logic                           s_axi_lite_wvalid,
  output logic                           s_axi_lite_wready,
  output logic [1:0]                     s_axi_lite_bresp,
  output logic                           s_axi_lite_bvalid,
  input  logic                           s_axi_lite_bready,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] s_axi_lite_araddr,
  input  logic                           s_axi_lite_arvalid,
  output logic                           s_axi_lite_arready,
  output logic [31:0]                    s_axi_lite_rdata,
  output logic [1:0]                     s_axi_lite_rresp,
  output logic                           s_axi_lite_rvalid,
  input  logic                           s_axi_lite_rready,
  input  logic                           frame_sync,
  output logic [32*REG_FILE_SIZE-1:0]    params_out,
  output logic                           params_updated
);
  localparam int IDXW = AXI_LITE_ADDR_WIDTH - 2;
  localparam int IW = (REG_FILE_SIZE > 1) ? $clog2(REG_FILE_SIZE) : 1;
  localparam logic [IDXW-1:0] STATUS_IDX = IDXW'(REG_FILE_SIZE);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_WRITE, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_READ} rstate_t;

  logic [31:0]                 r_work [REG_FILE_SIZE];
  logic [32*REG_FILE_SIZE-1:0] r_shadow;
  logic                        r_pending;
  logic [15:0]                 r_frame_count;
  logic                        r_params_updated;

  wstate_t          r_wstate;
  logic [IDXW-1:0]  r_awidx;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_awready, r_wready, r_bvalid;
  logic [1:0]       r_bresp;

  rstate_t          r_rstate;
  logic [IDXW-1:0]  r_aridx;
  logic             r_arready, r_rvalid;
  logic [31:0]      r_rdata;
  logic [1:0]       r_rresp;

  logic        w_wr_hit, w_wr_fire, w_commit, w_rd_hit, w_rd_status;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_wr_hit    = r_awidx < STATUS_IDX;
  assign w_wr_fire   = (r_wstate == W_WRITE) && w_wr_hit;
  assign w_commit    = frame_sync && r_pending;
  assign w_rd_hit    = r_aridx < STATUS_IDX;
  assign w_rd_status = r_aridx == STATUS_IDX;
  assign w_status    = {r_frame_count, 15'd0, r_pending};
  assign w_unused    = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

  // Write channel: AW and W may arrive in either order or together.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awidx   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (s_axi_lite_awvalid) r_awidx <= s_axi_lite_awaddr[AXI_LITE_ADDR_WIDTH-1:2];
          if (s_axi_lite_wvalid) begin
            r_wdata <= s_axi_lite_wdata;
            r_wstrb <= s_axi_lite_wstrb;
          end
          if (s_axi_lite_awvalid && s_axi_lite_wvalid) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_wstate  <= W_WRITE;
          end else if (s_axi_lite_awvalid) begin
            r_awready <= 1'b0;
            r_wstate  <= W_WAIT_DATA;
          end else if (s_axi_lite_wvalid) begin
            r_wready <= 1'b0;
            r_wstate <= W_WAIT_ADDR;
          end
        end
        W_WAIT_DATA: if (s_axi_lite_wvalid) begin
          r_wdata  <= s_axi_lite_wdata;
          r_wstrb  <= s_axi_lite_wstrb;
          r_wready <= 1'b0;
          r_wstate <= W_WRITE;
        end
        W_WAIT_ADDR: if (s_axi_lite_awvalid) begin
          r_awidx   <= s_axi_lite_awaddr[AXI_LITE_ADDR_WIDTH-1:2];
          r_awready <= 1'b0;
          r_wstate  <= W_WRITE;
        end
        W_WRITE: begin
          r_bresp  <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
          r_bvalid <= 1'b1;
          r_wstate <= W_RESP;
        end
        W_RESP: if (s_axi_lite_bready) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Commit copies the pre-write working array; a same-cycle write keeps pending set.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < REG_FILE_SIZE; i++) r_work[i] <= RESET_VALUES[32*i +: 32];
      r_shadow         <= RESET_VALUES;
      r_pending        <= 1'b0;
      r_frame_count    <= 16'd0;
      r_params_updated <= 1'b0;
    end else begin
      r_params_updated <= w_commit;
      if (frame_sync) r_frame_count <= r_frame_count + 16'd1;
      if (w_commit) begin
        for (int i = 0; i < REG_FILE_SIZE; i++) r_shadow[32*i +: 32] <= r_work[i];
      end
      if (w_wr_fire) begin
        for (int b = 0; b < 4; b++) begin
          if (r_wstrb[b]) r_work[r_awidx[IW-1:0]][8*b +: 8] <= r_wdata[8*b +: 8];
        end
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_aridx   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (s_axi_lite_arvalid) begin
          r_aridx   <= s_axi_lite_araddr[AXI_LITE_ADDR_WIDTH-1:2];
          r_arready <= 1'b0;
          r_rstate  <= R_FETCH;
        end
        R_FETCH: begin
          if (w_rd_hit) begin
            r_rdata <= r_work[r_aridx[IW-1:0]];
            r_rresp <= RESP_OKAY;
          end else if (w_rd_status) begin
            r_rdata <= w_status;
            r_rresp <= RESP_OKAY;
          end else begin
            r_rdata <= '0;
            r_rresp <= RESP_SLVERR;
          end
          r_rvalid <= 1'b1;
          r_rstate <= R_READ;
        end
        R_READ: if (s_axi_lite_rready) begin
          r_rvalid  <= 1'b0;
          r_arready <= 1'b1;
          r_rstate  <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi_lite_awready = r_awready;
  assign s_axi_lite_wready  = r_wready;
  assign s_axi_lite_bvalid  = r_bvalid;
  assign s_axi_lite_bresp   = r_bresp;
  assign s_axi_lite_arready = r_arready;
  assign s_axi_lite_rvalid  = r_rvalid;
  assign s_axi_lite_rdata   = r_rdata;
  assign s_axi_lite_rresp   = r_rresp;
  assign params_out         = r_shadow;
  assign params_updated     = r_params_updated;
endmodule

// File: tb/tb_ray_param_regfile.sv
// Randomised bench for ray_param_regfile against a register-level reference model.
module tb_ray_param_regfile;
  localparam int N = 16;

  function automatic logic [32*N-1:0] mk_rv();
    logic [32*N-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = 32'hC0DE_0000 + 32'(i * 17);
    return v;
  endfunction
  localparam logic [32*N-1:0] RV = mk_rv();

  logic aclk, aresetn;
  logic [7:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic frame_sync, params_updated;
  logic [32*N-1:0] params_out;

  ray_param_regfile #(.AXI_LITE_ADDR_WIDTH(8), .REG_FILE_SIZE(N), .RESET_VALUES(RV)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
    .s_axi_lite_wready(wready), .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid),
    .s_axi_lite_bready(bready), .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid),
    .s_axi_lite_arready(arready), .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
    .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready), .frame_sync(frame_sync),
    .params_out(params_out), .params_updated(params_updated)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Reference model: working/shadow arrays, pending flag, frame counter.
  logic [31:0] m_work [N];
  logic [31:0] m_shadow [N];
  bit          m_pending;
  logic [15:0] m_fc;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_work[i] = RV[32*i +: 32];
      m_shadow[i] = RV[32*i +: 32];
    end
    m_pending = 0;
    m_fc = 16'd0;
  endfunction

  function automatic logic [1:0] m_write(logic [7:0] a, logic [31:0] d, logic [3:0] s);
    int idx = int'(a >> 2);
    if (idx >= N) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) m_work[idx][8*b +: 8] = d[8*b +: 8];
    m_pending = 1;
    return 2'b00;
  endfunction

  function automatic bit m_fs();
    bit c = m_pending;
    m_fc = m_fc + 16'd1;
    if (c) begin
      for (int i = 0; i < N; i++) m_shadow[i] = m_work[i];
      m_pending = 0;
    end
    return c;
  endfunction

  function automatic logic [31:0] m_status();
    return {m_fc, 15'd0, m_pending};
  endfunction

  function automatic void m_read(logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int idx = int'(a >> 2);
    if (idx < N) begin d = m_work[idx]; r = 2'b00; end
    else if (idx == N) begin d = m_status(); r = 2'b00; end
    else begin d = 32'h0; r = 2'b10; end
  endfunction

  function automatic logic [32*N-1:0] m_flat();
    logic [32*N-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = m_shadow[i];
    return v;
  endfunction

  // Bus tasks start and end at posedge+1; a timeout leaves X in the outputs.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_acc, w_acc, got;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    resp = 2'bxx; got = 0;
    for (int c = 0; c < 20 && (awvalid || wvalid); c++) begin
      @(negedge aclk);
      aw_acc = awvalid && awready;
      w_acc = wvalid && wready;
      @(posedge aclk); #1;
      if (aw_acc) awvalid = 0;
      if (w_acc) wvalid = 0;
    end
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge aclk);
      if (bvalid) begin resp = bresp; got = 1; end
      @(posedge aclk); #1;
    end
    awvalid = 0; wvalid = 0; bready = 0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    bit acc, got;
    araddr = a; arvalid = 1; rready = 1; d = 'x; r = 'x; got = 0;
    for (int c = 0; c < 20 && arvalid; c++) begin
      @(negedge aclk);
      acc = arready;
      @(posedge aclk); #1;
      if (acc) arvalid = 0;
    end
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge aclk);
      if (rvalid) begin d = rdata; r = rresp; got = 1; end
      @(posedge aclk); #1;
    end
    arvalid = 0; rready = 0;
  endtask

  task automatic pulse_fs();
    bit exp;
    frame_sync = 1;
    @(posedge aclk); #1;
    frame_sync = 0;
    exp = m_fs();
    checks++;
    if (params_updated !== exp) begin errors++; $display("FAIL fs_updated got %b want %b", params_updated, exp); end
    checks++;
    if (params_out !== m_flat()) begin errors++; $display("FAIL fs_params got %h want %h", params_out, m_flat()); end
    @(posedge aclk); #1;
    checks++;
    if (params_updated !== 1'b0) begin errors++; $display("FAIL fs_updated_drop got %b want 0", params_updated); end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    aresetn = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; frame_sync = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    repeat (3) @(posedge aclk); #1;
    aresetn = 1;
    m_reset();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      errors++; $display("FAIL reset_hs got %b want 11100", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if ({bresp, rresp, rdata, params_updated} !== 37'd0) begin
      errors++; $display("FAIL reset_outs got %h/%h/%h/%b want 0", bresp, rresp, rdata, params_updated);
    end
    checks++;
    if (params_out !== RV) begin errors++; $display("FAIL reset_params got %h want %h", params_out, RV); end
    axi_read(8'(N * 4), d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL reset_status got %h/%b want 0/00", d, r); end
  endtask

  task automatic test_basic_commit();
    logic [31:0] d; logic [1:0] r, e;
    axi_write(8'd12, 32'h0100_0000, 4'hF, r);
    e = m_write(8'd12, 32'h0100_0000, 4'hF);
    checks++;
    if (r !== e) begin errors++; $display("FAIL basic_bresp got %b want %b", r, e); end
    axi_read(8'(N * 4), d, r);
    checks++;
    if (d !== 32'h0000_0001) begin errors++; $display("FAIL basic_status_pend got %h want 00000001", d); end
    axi_read(8'd12, d, r);
    checks++;
    if (d !== 32'h0100_0000 || r !== 2'b00) begin errors++; $display("FAIL basic_readback got %h want 01000000", d); end
    checks++;
    if (params_out[32*3 +: 32] !== RV[32*3 +: 32]) begin
      errors++; $display("FAIL basic_shadow_hold got %h want %h", params_out[32*3 +: 32], RV[32*3 +: 32]);
    end
    pulse_fs();
    checks++;
    if (params_out[32*3 +: 32] !== 32'h0100_0000) begin
      errors++; $display("FAIL basic_shadow_commit got %h want 01000000", params_out[32*3 +: 32]);
    end
    axi_read(8'(N * 4), d, r);
    checks++;
    if (d !== 32'h0001_0000) begin errors++; $display("FAIL basic_status_commit got %h want 00010000", d); end
  endtask

  task automatic test_strobe();
    logic [31:0] d; logic [1:0] r;
    axi_write(8'd20, 32'hAABB_CCDD, 4'hF, r);
    void'(m_write(8'd20, 32'hAABB_CCDD, 4'hF));
    axi_write(8'd20, 32'h1122_3344, 4'b0010, r);
    void'(m_write(8'd20, 32'h1122_3344, 4'b0010));
    axi_read(8'd20, d, r);
    checks++;
    if (d !== 32'hAABB_33DD) begin errors++; $display("FAIL strobe_readback got %h want aabb33dd", d); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d; logic [1:0] r;
    bit ok;
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1; bready = 0;
    @(posedge aclk); #1;
    wvalid = 0;
    @(posedge aclk); #1;
    awaddr = 8'd4; awvalid = 1;
    @(negedge aclk);
    ok = awready;
    @(posedge aclk); #1;
    awvalid = 0;
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL wfirst_awready got %b want 1", ok); end
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_bvalid_early got %b want 0", bvalid); end
    @(posedge aclk); #1;
    void'(m_write(8'd4, 32'h0BAD_F00D, 4'hF));
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++; $display("FAIL wfirst_bvalid_latency got %b/%b want 1/00", bvalid, bresp);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge aclk); #1;
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
        errors++; $display("FAIL wfirst_hold cycle %0d got %b/%b want 1/00", c, bvalid, bresp);
      end
    end
    bready = 1;
    @(posedge aclk); #1;
    bready = 0;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_bvalid_drop got %b want 0", bvalid); end
    axi_read(8'd4, d, r);
    checks++;
    if (d !== 32'h0BAD_F00D) begin errors++; $display("FAIL wfirst_readback got %h want 0badf00d", d); end
  endtask

  task automatic test_invalid();
    logic [31:0] d, ed; logic [1:0] r, er;
    bit acc = 0;
    araddr = 8'((N + 1) * 4); arvalid = 1; rready = 0;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(negedge aclk); acc = arready;
      @(posedge aclk); #1;
    end
    arvalid = 0;
    for (int c = 0; c < 10 && !rvalid; c++) begin @(posedge aclk); #1; end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h0 || rresp !== 2'b10) begin
        errors++; $display("FAIL inv_read cycle %0d got %b/%h/%b want 1/0/10", c, rvalid, rdata, rresp);
      end
      @(posedge aclk); #1;
    end
    rready = 1;
    @(posedge aclk); #1;
    rready = 0;
    axi_write(8'(N * 4), 32'hFFFF_FFFF, 4'hF, r);
    er = m_write(8'(N * 4), 32'hFFFF_FFFF, 4'hF);
    checks++;
    if (r !== er) begin errors++; $display("FAIL inv_status_wr got %b want %b", r, er); end
    axi_read(8'(N * 4), d, r);
    m_read(8'(N * 4), ed, er);
    checks++;
    if (d !== ed) begin errors++; $display("FAIL inv_status_keep got %h want %h", d, ed); end
  endtask

  task automatic test_same_cycle_commit();
    logic [31:0] d; logic [1:0] r;
    bit ok;
    axi_write(8'd8, 32'h2222_0002, 4'hF, r);
    void'(m_write(8'd8, 32'h2222_0002, 4'hF));
    awaddr = 8'd0; wdata = 32'h0000_F00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    @(negedge aclk);
    ok = awready && wready;
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; frame_sync = 1;
    @(posedge aclk); #1;
    frame_sync = 0;
    void'(m_fs());
    void'(m_write(8'd0, 32'h0000_F00D, 4'hF));
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL same_accept got %b want 1", ok); end
    checks++;
    if (params_updated !== 1'b1 || params_out !== m_flat()) begin
      errors++; $display("FAIL same_commit upd %b got %h want %h", params_updated, params_out, m_flat());
    end
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL same_bresp got %b/%b want 1/00", bvalid, bresp); end
    @(posedge aclk); #1;
    bready = 0;
    axi_read(8'(N * 4), d, r);
    checks++;
    if (d !== m_status()) begin errors++; $display("FAIL same_pending got %h want %h", d, m_status()); end
    pulse_fs();
    checks++;
    if (params_out[31:0] !== 32'h0000_F00D) begin errors++; $display("FAIL same_next_commit got %h want 0000f00d", params_out[31:0]); end
  endtask

  task automatic test_random();
    logic [31:0] d, ed, wd; logic [1:0] r, er;
    logic [7:0] a; logic [3:0] s;
    for (int it = 0; it < 60; it++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4 * N + 7));
      case ($urandom_range(0, 3))
        0, 1: begin
          wd = $urandom; s = 4'($urandom_range(0, 15));
          axi_write(a, wd, s, r);
          er = m_write(a, wd, s);
          checks++;
          if (r !== er) begin errors++; $display("FAIL rnd_bresp addr %h got %b want %b", a, r, er); end
        end
        2: begin
          axi_read(a, d, r);
          m_read(a, ed, er);
          checks++;
          if (d !== ed || r !== er) begin errors++; $display("FAIL rnd_read addr %h got %h/%b want %h/%b", a, d, r, ed, er); end
        end
        default: pulse_fs();
      endcase
    end
  endtask

  task automatic test_frame_wrap();
    logic [31:0] d; logic [1:0] r;
    int n = 16'hFFFF - int'(m_fc);
    if (n > 0) begin
      frame_sync = 1;
      repeat (n) @(posedge aclk);
      #1 frame_sync = 0;
      for (int k = 0; k < n; k++) void'(m_fs());
    end
    axi_read(8'(N * 4), d, r);
    checks++;
    if (d[31:16] !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h want ffff", d[31:16]); end
    pulse_fs();
    axi_read(8'(N * 4), d, r);
    checks++;
    if (d !== m_status() || d[31:16] !== 16'h0) begin errors++; $display("FAIL wrap_zero got %h want %h", d, m_status()); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d; logic [1:0] r;
    axi_write(8'd16, 32'h1234_5678, 4'hF, r);
    awaddr = 8'd16; awvalid = 1; wvalid = 0; bready = 1;
    @(posedge aclk); #1;
    awvalid = 0;
    checks++;
    if (awready !== 1'b0 || wready !== 1'b1) begin errors++; $display("FAIL mid_wait_data got %b%b want 01", awready, wready); end
    aresetn = 0;
    repeat (2) begin
      @(posedge aclk); #1;
      checks++;
      if (bvalid !== 1'b0) begin errors++; $display("FAIL mid_bvalid_rst got %b want 0", bvalid); end
    end
    aresetn = 1;
    m_reset();
    checks++;
    if (awready !== 1'b1 || wready !== 1'b1 || bvalid !== 1'b0) begin
      errors++; $display("FAIL mid_release got aw%b w%b b%b want 1 1 0", awready, wready, bvalid);
    end
    checks++;
    if (params_out !== RV) begin errors++; $display("FAIL mid_params got %h want %h", params_out, RV); end
    repeat (3) begin
      @(posedge aclk); #1;
      checks++;
      if (bvalid !== 1'b0) begin errors++; $display("FAIL mid_bvalid_after got %b want 0", bvalid); end
    end
    bready = 0;
    for (int i = 0; i < N; i++) begin
      axi_read(8'(i * 4), d, r);
      checks++;
      if (d !== RV[32*i +: 32]) begin errors++; $display("FAIL mid_reg%0d got %h want %h", i, d, RV[32*i +: 32]); end
    end
    axi_read(8'(N * 4), d, r);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_status got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_strobe();
    test_w_before_aw();
    test_invalid();
    test_same_cycle_commit();
    test_random();
    test_frame_wrap();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
